// File: rtl/leitor_matriz.sv
// Receiver for the multiplexed 5x7 LED-matrix scan bus: checks scan order and
// stability, rebuilds the column bitmaps and publishes whole frames only.
module leitor_matriz #(
  parameter int N_COLUNAS          = 5,
  parameter int N_LINHAS           = 7,
  parameter int COLUNA_ATIVA_BAIXO = 1,
  parameter int LINHA_ATIVA_BAIXO  = 0,
  parameter int ESTAVEL_MIN        = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_COLUNAS-1:0] colunas_in,
  input  logic [N_LINHAS-1:0]  linhas_in,
  output logic [N_LINHAS-1:0]  coluna1,
  output logic [N_LINHAS-1:0]  coluna2,
  output logic [N_LINHAS-1:0]  coluna3,
  output logic [N_LINHAS-1:0]  coluna4,
  output logic [N_LINHAS-1:0]  coluna5,
  output logic                 quadro_valido,
  output logic                 quadro_novo,
  output logic                 erro_varredura
);

  typedef enum logic {DESSINC = 1'b0, SINC = 1'b1} estado_t;

  localparam logic [3:0] MIN     = 4'(ESTAVEL_MIN);
  localparam logic [2:0] IDX_ULT = 3'(N_COLUNAS - 1);

  logic [N_COLUNAS-1:0]               col_n, col_r_q, col_p_q;
  logic [N_LINHAS-1:0]                lin_n, lin_r_q, lin_p_q;
  logic [3:0]                         cont_q, cont_d;
  logic                               cap_q, cap_d;
  logic                               um_quente, multi;
  logic [2:0]                         idx, ptr_q;
  estado_t                            estado_q;
  logic [N_COLUNAS-1:0][N_LINHAS-1:0] sombra_q, quadro_q;
  logic                               valido_q, novo_q, erro_q;

  assign col_n = (COLUNA_ATIVA_BAIXO != 0) ? ~colunas_in : colunas_in;
  assign lin_n = (LINHA_ATIVA_BAIXO != 0)  ? ~linhas_in  : linhas_in;

  // col_p/lin_p trail col_r by one cycle so the capture, which follows the
  // counter register, still sees the column and rows that made the dwell.
  always_comb begin
    um_quente = (col_r_q != '0) && ((col_r_q & (col_r_q - 1'b1)) == '0);
    multi     = (col_r_q != '0) && !um_quente;
    cont_d    = 4'd0;
    if (um_quente) begin
      if (col_r_q == col_p_q) cont_d = (cont_q == 4'd15) ? 4'd15 : cont_q + 4'd1;
      else                    cont_d = 4'd1;
    end
    cap_d = um_quente && (cont_d == MIN) && ((cont_q != MIN) || (col_r_q != col_p_q));
    idx   = 3'd0;
    for (int i = 0; i < N_COLUNAS; i++)
      if (col_p_q[i]) idx = 3'(i);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_r_q  <= '0;
      col_p_q  <= '0;
      lin_r_q  <= '0;
      lin_p_q  <= '0;
      cont_q   <= '0;
      cap_q    <= 1'b0;
      ptr_q    <= '0;
      estado_q <= DESSINC;
      sombra_q <= '0;
      quadro_q <= '0;
      valido_q <= 1'b0;
      novo_q   <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      col_r_q <= col_n;
      lin_r_q <= lin_n;
      col_p_q <= col_r_q;
      lin_p_q <= lin_r_q;
      cont_q  <= cont_d;
      cap_q   <= cap_d;
      novo_q  <= 1'b0;
      erro_q  <= 1'b0;
      if (multi) begin
        erro_q   <= 1'b1;
        estado_q <= DESSINC;
        ptr_q    <= '0;
        sombra_q <= '0;
      end else if (cap_q) begin
        case (estado_q)
          DESSINC: if (idx == 3'd0) begin
            sombra_q[0] <= lin_p_q;
            ptr_q       <= 3'd1;
            estado_q    <= SINC;
          end
          SINC: if (idx == ptr_q) begin
            sombra_q[idx] <= lin_p_q;
            if (idx == IDX_ULT) begin
              quadro_q          <= sombra_q;
              quadro_q[IDX_ULT] <= lin_p_q;
              novo_q            <= 1'b1;
              valido_q          <= 1'b1;
              ptr_q             <= '0;
            end else begin
              ptr_q <= ptr_q + 3'd1;
            end
          end else if (idx == 3'd0) begin
            // Out of order, but a column-1 select is a valid frame start.
            erro_q      <= 1'b1;
            sombra_q[0] <= lin_p_q;
            ptr_q       <= 3'd1;
          end else begin
            erro_q   <= 1'b1;
            estado_q <= DESSINC;
            ptr_q    <= '0;
          end
          default: estado_q <= DESSINC;
        endcase
      end
    end
  end

  assign coluna1        = quadro_q[0];
  assign coluna2        = quadro_q[1];
  assign coluna3        = quadro_q[2];
  assign coluna4        = quadro_q[3];
  assign coluna5        = quadro_q[4];
  assign quadro_valido  = valido_q;
  assign quadro_novo    = novo_q;
  assign erro_varredura = erro_q;

endmodule

// File: tb/tb_leitor_matriz.sv
// Scoreboard bench for leitor_matriz: directed scan sequences push expected
// frames; a negedge monitor pops and compares on every quadro_novo pulse.
module tb_leitor_matriz;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] colunas_in;
  logic [6:0] linhas_in;
  logic [6:0] coluna1, coluna2, coluna3, coluna4, coluna5;
  logic       quadro_valido, quadro_novo, erro_varredura;

  leitor_matriz dut (
    .clock(clock), .reset(reset), .colunas_in(colunas_in), .linhas_in(linhas_in),
    .coluna1(coluna1), .coluna2(coluna2), .coluna3(coluna3), .coluna4(coluna4),
    .coluna5(coluna5), .quadro_valido(quadro_valido), .quadro_novo(quadro_novo),
    .erro_varredura(erro_varredura)
  );

  always #5 clock = ~clock;

  int checks = 0, passed = 0;
  int cyc = 0, t_c5 = 0;
  int pubs = 0, errs = 0;
  bit lat_chk = 0;
  logic [34:0] fila[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nome, input logic [34:0] got, input logic [34:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nome, got, exp);
  endtask

  function automatic logic [34:0] quadro();
    return {coluna5, coluna4, coluna3, coluna2, coluna1};
  endfunction

  function automatic logic [34:0] mk(input logic [6:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  // Monitor / scoreboard
  always @(negedge clock) begin
    if (!reset) begin
      if (erro_varredura) errs++;
      if (quadro_novo) begin
        pubs++;
        if (fila.size() == 0) begin
          chk("publish_unexpected", 35'(pubs), 35'(0));
        end else begin
          chk("frame", quadro(), fila.pop_front());
          chk("valido_at_publish", 35'(quadro_valido), 35'(1));
        end
        if (lat_chk) begin
          chk("latency", 35'(cyc - t_c5), 35'(4));
          lat_chk = 0;
        end
      end
    end
  end

  task automatic drv(input int c, input logic [6:0] r, input int n);
    logic [4:0] v;
    v = 5'b00001 << c;
    colunas_in = ~v;
    linhas_in  = r;
    if (c == 4) t_c5 = cyc;
    repeat (n) @(negedge clock);
  endtask

  task automatic blank(input int n);
    colunas_in = 5'h1F;
    linhas_in  = 7'h00;
    repeat (n) @(negedge clock);
  endtask

  task automatic sweep(input logic [34:0] f);
    for (int c = 0; c < 5; c++) drv(c, f[c*7 +: 7], 4);
  endtask

  task automatic end_test(input string nome, input int exp_pub, input int exp_err);
    blank(8);
    chk({nome, "_pubs"}, 35'(pubs), 35'(exp_pub));
    chk({nome, "_errs"}, 35'(errs), 35'(exp_err));
    chk({nome, "_queue_empty"}, 35'(fila.size()), 35'(0));
    pubs = 0;
    errs = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    blank(2);
    chk("reset_frame", quadro(), 35'(0));
    chk("reset_flags", {32'(0), quadro_valido, quadro_novo, erro_varredura}, 35'(0));
    reset = 1'b0;
  endtask

  logic [34:0] f1, f2, f3, f4, f5, f6;

  initial begin
    f1 = mk(7'h01, 7'h02, 7'h04, 7'h08, 7'h7F);
    f2 = mk(7'h41, 7'h22, 7'h14, 7'h08, 7'h77);
    f3 = mk(7'h11, 7'h22, 7'h33, 7'h44, 7'h55);
    f4 = mk(7'h70, 7'h0E, 7'h5A, 7'h25, 7'h3C);
    f5 = mk(7'h7E, 7'h01, 7'h40, 7'h2A, 7'h15);
    f6 = mk(7'h12, 7'h34, 7'h56, 7'h78, 7'h1A);
    reset      = 1'b1;
    colunas_in = 5'h1F;
    linhas_in  = 7'h00;
    @(negedge clock);
    do_reset();

    // 1: two clean sweeps, latency on the first
    fila.push_back(f1);
    fila.push_back(f1);
    lat_chk = 1;
    sweep(f1);
    sweep(f1);
    end_test("t1", 2, 0);
    chk("t1_frame_held", quadro(), f1);

    // 2: start mid-sweep after reset
    do_reset();
    drv(2, 7'h5A, 4); drv(3, 7'h5A, 4); drv(4, 7'h5A, 4);
    chk("t2_no_early_frame", quadro(), 35'(0));
    fila.push_back(f2);
    sweep(f2);
    end_test("t2", 1, 0);

    // 3: skip column 3 in SINC, old frame held, then recover
    drv(0, 7'h7F, 4); drv(1, 7'h7F, 4); drv(3, 7'h7F, 4); drv(4, 7'h7F, 4);
    blank(6);
    chk("t3_hold", quadro(), f2);
    end_test("t3a", 0, 1);
    fila.push_back(f3);
    sweep(f3);
    end_test("t3b", 1, 0);

    // 4a: one-cycle column-2 glitch between dwells is filtered
    fila.push_back(f4);
    drv(0, f4[6:0], 4);
    drv(1, 7'h7F, 1);
    blank(2);
    for (int c = 1; c < 5; c++) drv(c, f4[c*7 +: 7], 4);
    end_test("t4a", 1, 0);
    // 4b: glitch replacing column 2 makes column 3 out of order
    drv(0, 7'h01, 4); drv(1, 7'h02, 1); drv(2, 7'h03, 4); drv(3, 7'h04, 4); drv(4, 7'h05, 4);
    end_test("t4b", 0, 1);
    chk("t4b_hold", quadro(), f4);

    // 5: two-hot select mid-frame
    drv(0, 7'h7F, 4); drv(1, 7'h7F, 4);
    colunas_in = 5'b11100;
    @(negedge clock);
    blank(2);
    drv(2, 7'h7F, 4); drv(3, 7'h7F, 4); drv(4, 7'h7F, 4);
    end_test("t5a", 0, 1);
    chk("t5_hold", quadro(), f4);
    fila.push_back(f5);
    sweep(f5);
    end_test("t5b", 1, 0);

    // 6: asynchronous reset during column 4 of the second frame
    fila.push_back(f6);
    sweep(f6);
    end_test("t6a", 1, 0);
    drv(0, 7'h01, 4); drv(1, 7'h01, 4); drv(2, 7'h01, 4); drv(3, 7'h01, 2);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_frame", quadro(), 35'(0));
    chk("t6_async_valido", 35'(quadro_valido), 35'(0));
    @(negedge clock);
    reset = 1'b0;
    drv(3, 7'h01, 2); drv(4, 7'h01, 4);
    end_test("t6b", 0, 0);
    chk("t6_still_clear", {quadro(), 1'b0} | 36'(quadro_valido), 36'(0));
    fila.push_back(f1);
    sweep(f1);
    end_test("t6c", 1, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
